// File: rtl/gf2m8_mul_icg_if.sv
// ---------------------------------------------------------------------------
// gf2m8_mul_icg_if -- signal bundle for the GF(2^8) multiplier / clock gate.
//
//   ena   : clock-gate enable request          (master -> slave)
//   gclk  : gated clock                        (slave  -> master)
//   x     : GF(2^8) multiplicand, 8 bits       (master -> slave)
//   y     : GF(2^8) multiplier, 8 bits         (master -> slave)
//   z     : GF(2^8) product x*y, 8 bits        (slave  -> master)
//
// The slave modport is the view taken by gf2m8_mul_icg; the master modport
// is the view taken by whatever drives it.
// ---------------------------------------------------------------------------
interface gf2m8_mul_icg_if;
  logic       ena;
  logic       gclk;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] z;

  modport master (
    output ena, x, y,
    input  gclk, z
  );

  modport slave (
    input  ena, x, y,
    output gclk, z
  );
endinterface

// File: rtl/gf2m8_mul_icg.sv
// ---------------------------------------------------------------------------
// gf2m8_mul_icg -- combinational GF(2^8) multiplier plus a latch-based
// integrated clock gate.
//
//   clk       : the single clock
//   rst       : synchronous active-high reset; while high it forces the
//               clock gate open so downstream reset flops see edges
//   bus.ena   : clock-gate enable request
//   bus.gclk  : gated clock, clk AND (ena|rst latched during clk low)
//   bus.x/y   : GF(2^8) operands, bit 0 = x^0 coefficient
//   bus.z     : x*y reduced modulo x^8+x^4+x^3+x^2+1 (0x11D), zero latency
//
// The block holds no flip-flops: the multiplier is pure logic and the only
// storage is the clock-gate latch, so reset has no register to clear.
// ---------------------------------------------------------------------------
module gf2m8_mul_icg (
  input  logic                 clk,
  input  logic                 rst,
  gf2m8_mul_icg_if.slave       bus
);

  localparam logic [8:0] POLY = 9'h11D;

  // -------------------------------------------------------------------------
  // Multiplier: carry-less product, then fold bits 14..8 back into the field.
  // -------------------------------------------------------------------------
  logic [14:0] prod;
  logic [14:0] red;

  // NOTE: always_comb uses blocking '=' so each loop pass sees the value
  // accumulated by the previous pass; every target gets a default first so
  // no latch is inferred.
  always_comb begin
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      if (bus.y[i]) prod = prod ^ ({7'b0, bus.x} << i);
    end
  end

  // Reduce from the top bit down so a fold that sets a lower high-order bit
  // is itself folded on a later pass.
  always_comb begin
    red = prod;
    for (int i = 14; i >= 8; i--) begin
      if (red[i]) red = red ^ ({6'b0, POLY} << (i - 8));
    end
  end

  assign bus.z = red[7:0];

  // -------------------------------------------------------------------------
  // Clock gate: latch the enable while clk is low, hold it while clk is high.
  // Reset forces the gate open.
  // -------------------------------------------------------------------------
  logic en_eff;
  logic en_lat;

  assign en_eff = bus.ena | rst;

  // NOTE: this latch is intentional -- transparent only during clk low, so
  // any enable change during clk high is blocked until the next low phase,
  // which is what keeps gclk free of truncated or extra pulses.
  always_latch begin
    if (!clk) en_lat <= en_eff;
  end

  assign bus.gclk = clk & en_lat;

endmodule

// File: tb/tb_gf2m8_mul_icg.sv
// ---------------------------------------------------------------------------
// tb_gf2m8_mul_icg -- self-checking bench for gf2m8_mul_icg.
// The multiplier reference is a shift-and-XOR (xtime) model; the clock-gate
// reference is "one gclk pulse per cycle whose low-phase ena|rst was high".
// ---------------------------------------------------------------------------
module tb_gf2m8_mul_icg;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  int   pulse_cnt;

  gf2m8_mul_icg_if bus ();

  gf2m8_mul_icg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge bus.gclk) pulse_cnt++;

  // Field multiply by repeated doubling (xtime) with reduction by 0x1D.
  function automatic logic [7:0] ref_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       carry;
    a = a_in;
    b = b_in;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      carry = a[7];
      a     = a << 1;
      if (carry) a = a ^ 8'h1D;
      b     = b >> 1;
    end
    return r;
  endfunction

  task automatic apply_mul(input logic [7:0] a, input logic [7:0] b, input string name);
    logic [7:0] exp_z;
    bus.x = a;
    bus.y = b;
    #1;
    exp_z = ref_mul(a, b);
    n_checks++;
    if (bus.z !== exp_z) begin
      n_fails++;
      $display("FAIL %s: x=%h y=%h got z=%h expected %h", name, a, b, bus.z, exp_z);
    end
  endtask

  // Caller is in the clk-low phase. Drives ena/rst, checks gclk in the high
  // phase and again after the falling edge, and returns in the next low phase.
  task automatic run_cycle(input logic e, input logic r, input string name);
    bus.ena = e;
    rst     = r;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.gclk !== (e | r)) begin
      n_fails++;
      $display("FAIL %s high: got gclk=%b expected %b", name, bus.gclk, e | r);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.gclk !== 1'b0) begin
      n_fails++;
      $display("FAIL %s low: got gclk=%b expected 0", name, bus.gclk);
    end
    #1;
  endtask

  task automatic check_pulses(input int start, input int want, input string name);
    n_checks++;
    if (pulse_cnt - start !== want) begin
      n_fails++;
      $display("FAIL %s: got %0d gclk pulses expected %0d", name, pulse_cnt - start, want);
    end
  endtask

  task automatic test_reset();
    int start;
    @(negedge clk);
    #2;
    start = pulse_cnt;
    run_cycle(1'b0, 1'b1, "reset_open_0");
    apply_mul(8'h57, 8'h83, "mul_during_reset");
    run_cycle(1'b0, 1'b1, "reset_open_1");
    run_cycle(1'b0, 1'b0, "after_reset_0");
    run_cycle(1'b0, 1'b0, "after_reset_1");
    check_pulses(start, 2, "reset_pulse_count");
  endtask

  task automatic test_mul_directed();
    apply_mul(8'h00, 8'hA7, "zero_xy");
    apply_mul(8'hA7, 8'h00, "zero_yx");
    apply_mul(8'h01, 8'hA7, "ident_xy");
    apply_mul(8'hA7, 8'h01, "ident_yx");
    apply_mul(8'h02, 8'h80, "reduce_02_80");
    apply_mul(8'h03, 8'h80, "reduce_03_80");
    apply_mul(8'hFF, 8'h02, "reduce_ff_02");
    // Hard constants as a cross-check of the model itself.
    bus.x = 8'h02; bus.y = 8'h80; #1;
    n_checks++;
    if (bus.z !== 8'h1D) begin
      n_fails++;
      $display("FAIL const_02_80: got %h expected 1d", bus.z);
    end
    bus.x = 8'hFF; bus.y = 8'h02; #1;
    n_checks++;
    if (bus.z !== 8'hE3) begin
      n_fails++;
      $display("FAIL const_ff_02: got %h expected e3", bus.z);
    end
  endtask

  task automatic test_mul_exhaustive();
    logic [7:0] res [0:65535];
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        apply_mul(8'(a), 8'(b), "exhaustive");
        res[a * 256 + b] = bus.z;
      end
    end
    for (int a = 0; a < 256; a++) begin
      for (int b = a + 1; b < 256; b++) begin
        n_checks++;
        if (res[a * 256 + b] !== res[b * 256 + a]) begin
          n_fails++;
          $display("FAIL commutative: x=%h y=%h got %h vs swapped %h",
                   8'(a), 8'(b), res[a * 256 + b], res[b * 256 + a]);
        end
      end
    end
  endtask

  task automatic test_mul_random();
    for (int i = 0; i < 200; i++) begin
      apply_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random_mul");
    end
  endtask

  task automatic test_gate_enable();
    int start;
    start = pulse_cnt;
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, "gate_on");
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, "gate_off");
    check_pulses(start, 3, "gate_pulse_count");
  endtask

  task automatic test_glitch();
    int start;
    start = pulse_cnt;
    // ena drops mid-high: current pulse must complete, next cycle is gated.
    bus.ena = 1'b1;
    @(posedge clk);
    #2 bus.ena = 1'b0;
    #1;
    n_checks++;
    if (bus.gclk !== 1'b1) begin
      n_fails++;
      $display("FAIL glitch_fall_trunc: got gclk=%b expected 1", bus.gclk);
    end
    @(negedge clk);
    #2;
    run_cycle(1'b0, 1'b0, "glitch_fall_next");
    // ena rises mid-high: no pulse now, pulse on the following cycle.
    @(posedge clk);
    #2 bus.ena = 1'b1;
    #1;
    n_checks++;
    if (bus.gclk !== 1'b0) begin
      n_fails++;
      $display("FAIL glitch_rise_extra: got gclk=%b expected 0", bus.gclk);
    end
    @(negedge clk);
    #2;
    run_cycle(1'b1, 1'b0, "glitch_rise_next");
    // rst rises mid-high with ena low: also deferred to the next cycle.
    bus.ena = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.gclk !== 1'b0) begin
      n_fails++;
      $display("FAIL glitch_rst_extra: got gclk=%b expected 0", bus.gclk);
    end
    @(negedge clk);
    #2;
    run_cycle(1'b0, 1'b1, "glitch_rst_next");
    run_cycle(1'b0, 1'b0, "glitch_rst_release");
    check_pulses(start, 3, "glitch_pulse_count");
  endtask

  task automatic test_gate_random();
    int   start;
    int   want;
    logic e;
    logic r;
    start = pulse_cnt;
    want  = 0;
    for (int i = 0; i < 40; i++) begin
      e = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 7) == 0);
      if (e | r) want++;
      run_cycle(e, r, "random_gate");
    end
    run_cycle(1'b0, 1'b0, "random_gate_idle");
    check_pulses(start, want, "random_gate_pulse_count");
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    pulse_cnt = 0;
    rst       = 1'b1;
    bus.ena   = 1'b0;
    bus.x     = 8'h00;
    bus.y     = 8'h00;
    test_reset();
    test_mul_directed();
    test_mul_random();
    test_gate_enable();
    test_glitch();
    test_gate_random();
    test_mul_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gf2m8_mul_icg.md
GF2M8_MUL_ICG -- requirements
Module: gf2m8_mul_icg

Interface
REQ-001 The block SHALL have no parameters; field width is fixed at 8 bits.
REQ-002 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-003 Port clk, input, 1 bit: the single clock.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port ena, input, 1 bit: clock-gate enable request.
REQ-006 Port gclk, output, 1 bit: gated clock derived from clk.
REQ-007 Port x, input, 8 bits: GF(2^8) multiplicand.
REQ-008 Port y, input, 8 bits: GF(2^8) multiplier.
REQ-009 Port z, output, 8 bits: GF(2^8) product x·y.

Function
REQ-010 z SHALL be purely combinational in x and y, with zero-cycle latency and no dependence on clk, rst or ena.
REQ-011 The field SHALL be GF(2^8) with primitive polynomial p(x) = x^8+x^4+x^3+x^2+1 (0x11D); bit 0 of each bus is the x^0 coefficient.
REQ-012 Product computation: form the 15-bit carry-less polynomial product of x and y (partial products ANDed, summed by XOR).
REQ-013 Reduction: reduce bits 14..8 modulo 0x11D, so z is always a fully reduced 8-bit value.
REQ-014 The multiplier SHALL be commutative (z(x,y) = z(y,x)).
REQ-015 Multiplying by 0x00 SHALL give 0x00, and 0x01 SHALL be the identity.
REQ-016 The multiplier SHALL hold no state and SHALL produce no X on z for known inputs.
REQ-017 Clock gate: an internal level-sensitive latch SHALL capture en_eff = ena | rst while clk is low and hold it while clk is high.
REQ-018 gclk SHALL equal clk AND latched en_eff.
REQ-019 gclk SHALL be glitch-free: a change on ena or rst during clk high has no effect on gclk until the next clk-low phase.
REQ-020 If en_eff is high during the low phase before rising edge N, gclk SHALL pulse coincident with clk high phase N; otherwise gclk stays low for that whole period.
REQ-021 gclk SHALL never be high while clk is low.

Reset
REQ-022 While rst is high, the gate SHALL be forced open (gclk = clk) so downstream synchronous-reset flops receive edges.
REQ-023 After rst deasserts, gating SHALL follow ena from the next clk-low phase.
REQ-024 Reset mid-operation SHALL not affect z.
REQ-025 There SHALL be no asynchronous reset path.
REQ-026 Before the first clk-low phase after power-up the latch value is don't-care; benches SHALL assert rst for at least 1 clk cycle to define gclk.

Verification
REQ-027 Multiplier identity/zero: x=0x00 with y=0xA7 -> z=0x00; x=0x01 with y=0xA7 -> z=0xA7; swapping operands gives the same z.
REQ-028 Multiplier reduction: 0x02·0x80 -> 0x1D; 0x03·0x80 -> 0x9D; 0xFF·0x02 -> 0xE3.
REQ-029 Multiplier exhaustive: all 65536 (x,y) pairs SHALL match a shift-and-XOR reference model using 0x11D, and SHALL be commutative.
REQ-030 Gate enable: rst=0, ena=1 for 3 cycles then 0 -> exactly 3 gclk pulses aligned to clk high, then gclk stays low.
REQ-031 Glitch check: ena toggled mid clk-high phase -> gclk shows no truncated or extra pulse; the new value takes effect on the following cycle.
REQ-032 Reset override: rst=1, ena=0 for 2 cycles -> 2 gclk pulses; after rst falls with ena=0 -> no further pulses.
